line_write_merge: RTL and testbench



---
 rtl/line_write_merge.sv | 146 ++++++++++++++
 tb/tb_line_write_merge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_write_merge.sv
`default_nettype none
// ============================================================================
//  Module   : line_write_merge
//  Purpose  : Single-line write-merge buffer. Captures a full cache line,
//             merges byte-masked word writes into it while tracking which
//             words were modified, then drains the merged line plus a
//             per-word dirty mask over a valid/ready handshake. A new line
//             may be captured in the same cycle the drained line is taken.
//  Ports    : clk, reset        - clock, asynchronous active-high reset
//             load_valid/ready  - line capture handshake, load_data = line
//             wr_valid/ready    - word write handshake (wr_sel, wr_data,
//                                 wr_strb byte enables)
//             flush             - one-cycle request to drain the held line
//             out_valid/ready   - drain handshake, out_data = merged line,
//                                 out_dirty = per-word modified mask
//  Revision : 1.0 - initial release
// ============================================================================
module line_write_merge #(
  parameter int WORD_LOG   = 3,
  parameter int DATA_WIDTH = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_valid,
  output logic                                    load_ready,
  input  logic [(2**WORD_LOG)-1:0][DATA_WIDTH-1:0] load_data,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [WORD_LOG-1:0]                     wr_sel,
  input  logic [DATA_WIDTH-1:0]                   wr_data,
  input  logic [(DATA_WIDTH/8)-1:0]               wr_strb,
  input  logic                                    flush,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [(2**WORD_LOG)-1:0][DATA_WIDTH-1:0] out_data,
  output logic [(2**WORD_LOG)-1:0]                out_dirty
);

  localparam int C_NWORDS = 2**WORD_LOG;
  localparam int C_NBYTES = DATA_WIDTH / 8;

  generate
    if ((DATA_WIDTH % 8) != 0) begin : g_width_check
      $error("line_write_merge: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [C_NWORDS-1:0][DATA_WIDTH-1:0]  r_line;
  logic [C_NWORDS-1:0]                  r_dirty;
  logic                                 w_load_fire;
  logic                                 w_wr_fire;
  logic [DATA_WIDTH-1:0]                w_merged;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    wr_ready    = 1'b0;
    out_valid   = 1'b0;
    w_load_fire = 1'b0;
    w_wr_fire   = 1'b0;
    case (r_state)
      S_EMPTY: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_load_fire = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        wr_ready  = 1'b1;
        w_wr_fire = wr_valid;
        // A write in the flush cycle is still merged by the datapath below.
        if (flush) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        // Accepting a load while the line is taken avoids a bubble cycle.
        load_ready = out_ready;
        if (out_ready) begin
          if (load_valid) begin
            w_load_fire = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_EMPTY;
          end
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // Byte-masked merge of the write data into the selected word
  always_comb begin
    w_merged = r_line[wr_sel];
    for (int b = 0; b < C_NBYTES; b++) begin
      if (wr_strb[b]) begin
        w_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Line and dirty-mask registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_line  <= '0;
      r_dirty <= '0;
    end else if (w_load_fire) begin
      r_line  <= load_data;
      r_dirty <= '0;
    end else if (w_wr_fire) begin
      r_line[wr_sel] <= w_merged;
      // A zero-strobe write is accepted but must not mark the word dirty.
      if (|wr_strb) begin
        r_dirty[wr_sel] <= 1'b1;
      end
    end
  end

  // The retained line is hidden once drained so EMPTY always reads zero.
  assign out_data  = (r_state == S_EMPTY) ? '0 : r_line;
  assign out_dirty = (r_state == S_EMPTY) ? '0 : r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_line_write_merge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_write_merge
//  Purpose  : Directed self-checking bench for line_write_merge with
//             hand-computed expected lines and dirty masks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_write_merge;

  localparam int C_WL = 3;
  localparam int C_DW = 64;
  localparam int C_NW = 2**C_WL;

  logic                          clk;
  logic                          reset;
  logic                          load_valid;
  logic                          load_ready;
  logic [C_NW-1:0][C_DW-1:0]     load_data;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [C_WL-1:0]               wr_sel;
  logic [C_DW-1:0]               wr_data;
  logic [(C_DW/8)-1:0]           wr_strb;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [C_NW-1:0][C_DW-1:0]     out_data;
  logic [C_NW-1:0]               out_dirty;

  int n_checks;
  int n_fail;

  logic [C_NW-1:0][C_DW-1:0] r_exp;

  line_write_merge #(
    .WORD_LOG   (C_WL),
    .DATA_WIDTH (C_DW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_dirty  (out_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [C_NW-1:0][C_DW-1:0] line);
    load_data  = line;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_write(input logic [C_WL-1:0] sel, input logic [C_DW-1:0] data,
                          input logic [7:0] strb);
    wr_sel   = sel;
    wr_data  = data;
    wr_strb  = strb;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic do_drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [C_NW-1:0][C_DW-1:0] v_line;
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    wr_valid   = 1'b0;
    wr_sel     = '0;
    wr_data    = '0;
    wr_strb    = '0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_load_ready", 512'(load_ready), 512'(1'b1));
    check("rst_wr_ready",   512'(wr_ready),   512'(1'b0));
    check("rst_out_valid",  512'(out_valid),  512'(1'b0));
    check("rst_out_data",   512'(out_data),   512'(0));
    check("rst_out_dirty",  512'(out_dirty),  512'(0));

    // Load ramp, flush without writes
    for (int i = 0; i < C_NW; i++) v_line[i] = 64'(i);
    do_load(v_line);
    check("t1_hold_wr_ready",   512'(wr_ready),   512'(1'b1));
    check("t1_hold_load_ready", 512'(load_ready), 512'(1'b0));
    check("t1_hold_out_valid",  512'(out_valid),  512'(1'b0));
    check("t1_hold_line",       512'(out_data),   512'(v_line));
    do_flush();
    check("t1_out_valid", 512'(out_valid), 512'(1'b1));
    check("t1_out_data",  512'(out_data),  512'(v_line));
    check("t1_out_dirty", 512'(out_dirty), 512'(8'h00));
    do_drain();
    check("t1_empty_load_ready", 512'(load_ready), 512'(1'b1));
    check("t1_empty_out_valid",  512'(out_valid),  512'(1'b0));
    check("t1_empty_out_data",   512'(out_data),   512'(0));

    // Single half-word strobe write
    do_load('0);
    do_write(3'd5, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
    check("t2_merge_visible", 512'(out_data[5]), 512'(64'h0000_0000_CAFE_F00D));
    do_flush();
    r_exp    = '0;
    r_exp[5] = 64'h0000_0000_CAFE_F00D;
    check("t2_out_data",  512'(out_data),  512'(r_exp));
    check("t2_out_dirty", 512'(out_dirty), 512'(8'h20));
    do_drain();

    // Accumulation and zero-strobe write
    do_load('0);
    do_write(3'd2, {64{1'b1}}, 8'hFF);
    do_write(3'd2, 64'h0, 8'h80);
    do_write(3'd7, {64{1'b1}}, 8'h00);
    do_flush();
    r_exp    = '0;
    r_exp[2] = 64'h00FF_FFFF_FFFF_FFFF;
    check("t3_out_data",  512'(out_data),  512'(r_exp));
    check("t3_out_dirty", 512'(out_dirty), 512'(8'h04));
    do_drain();

    // Write and flush in the same cycle
    do_load('0);
    wr_sel   = 3'd1;
    wr_data  = 64'h1234;
    wr_strb  = 8'hFF;
    wr_valid = 1'b1;
    flush    = 1'b1;
    tick();
    wr_valid = 1'b0;
    flush    = 1'b0;
    r_exp    = '0;
    r_exp[1] = 64'h1234;
    check("t4_out_valid", 512'(out_valid), 512'(1'b1));
    check("t4_out_data",  512'(out_data),  512'(r_exp));
    check("t4_out_dirty", 512'(out_dirty), 512'(8'h02));

    // Backpressure: writes and flush offered while stalled must be ignored
    wr_sel   = 3'd0;
    wr_data  = {64{1'b1}};
    wr_strb  = 8'hFF;
    wr_valid = 1'b1;
    flush    = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check("t5_stall_out_valid",  512'(out_valid),  512'(1'b1));
      check("t5_stall_wr_ready",   512'(wr_ready),   512'(1'b0));
      check("t5_stall_load_ready", 512'(load_ready), 512'(1'b0));
      tick();
      check("t5_stall_out_data",   512'(out_data),   512'(r_exp));
      check("t5_stall_out_dirty",  512'(out_dirty),  512'(8'h02));
    end
    wr_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < C_NW; i++) v_line[i] = 64'(100 + i);
    load_data  = v_line;
    load_valid = 1'b1;
    out_ready  = 1'b1;
    #1;
    check("t5_load_ready_passthru", 512'(load_ready), 512'(1'b1));
    tick();
    load_valid = 1'b0;
    out_ready  = 1'b0;
    check("t5_b2b_out_valid", 512'(out_valid), 512'(1'b0));
    check("t5_b2b_wr_ready",  512'(wr_ready),  512'(1'b1));
    check("t5_b2b_out_dirty", 512'(out_dirty), 512'(8'h00));
    check("t5_b2b_line",      512'(out_data),  512'(v_line));

    // Asynchronous reset mid-cycle after dirty writes
    do_write(3'd3, 64'hAAAA, 8'h03);
    do_write(3'd6, 64'hBBBB, 8'hFF);
    check("t6_pre_dirty", 512'(out_dirty), 512'(8'h48));
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_out_valid",  512'(out_valid),  512'(1'b0));
    check("t6_async_wr_ready",   512'(wr_ready),   512'(1'b0));
    check("t6_async_load_ready", 512'(load_ready), 512'(1'b1));
    check("t6_async_out_dirty",  512'(out_dirty),  512'(0));
    check("t6_async_out_data",   512'(out_data),   512'(0));
    tick();
    reset = 1'b0;
    tick();
    check("t6_post_rst_load_ready", 512'(load_ready), 512'(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
